// File: rtl/crc16_pkg.sv
// Shared CRC16 (poly 0x8005, init 0, MSB first, no reflection) definitions
// for the serial generator and the frame checker.
package crc16_pkg;

    localparam int unsigned CRC_WIDTH     = 16;
    localparam logic [15:0] CRC_POLY      = 16'h8005;
    localparam logic [15:0] CRC_INIT      = 16'h0000;
    localparam int unsigned CRC_MIN_FRAME = 17;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        DROP
    } state_e;

    // One serial LFSR step; the feedback bit is the incoming bit xor the register MSB.
    function automatic logic [CRC_WIDTH-1:0] crc16_step(input logic [CRC_WIDTH-1:0] crc,
                                                        input logic                 din);
        logic fb;
        fb = din ^ crc[CRC_WIDTH-1];
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// 16-bit serial CRC register. clr_i reseeds to CRC_INIT; when combined with en_i
// the accepted bit is folded into the fresh seed rather than the stale value.
module crc16_lfsr
    import crc16_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 data_i,
    output logic [CRC_WIDTH-1:0] crc_o,
    output logic [CRC_WIDTH-1:0] crc_next_o
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] base;

    always_comb begin
        base       = clr_i ? CRC_INIT : crc_q;
        crc_next_o = en_i ? crc16_step(base, data_i) : base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_next_o;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC16 frame checker: runs the LFSR over payload plus appended CRC
// and reports residue, pass/fail and length status one cycle after the last bit.
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter int unsigned  MAX_FRAME_BITS = 4096,
    parameter int unsigned  MIN_FRAME_BITS = CRC_MIN_FRAME,
    localparam int unsigned CW             = $clog2(MAX_FRAME_BITS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 crc_ok_o,
    output logic                 len_err_o,
    output logic [CW-1:0]        frame_bits_o,
    output logic [CRC_WIDTH-1:0] residue_o
);

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        bits_acc;
    logic                 lfsr_clr, lfsr_en;
    logic [CRC_WIDTH-1:0] lfsr_q, lfsr_next;
    logic                 frame_end;
    logic                 len_err_d;
    logic [CRC_WIDTH-1:0] residue_d;

    logic                 done_q;
    logic                 crc_ok_q;
    logic                 len_err_q;
    logic [CW-1:0]        frame_bits_q;
    logic [CRC_WIDTH-1:0] residue_q;

    crc16_lfsr u_lfsr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (lfsr_clr),
        .en_i       (lfsr_en),
        .data_i     (data_i),
        .crc_o      (lfsr_q),
        .crc_next_o (lfsr_next)
    );

    // Abort outranks valid only while a frame is open; in IDLE it is ignored.
    assign frame_end = valid_i && last_i && !(abort_i && (state_q != IDLE));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        bits_acc = count_q;
        lfsr_clr = 1'b0;
        lfsr_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    lfsr_clr = 1'b1;
                    lfsr_en  = 1'b1;
                    bits_acc = CW'(1);
                    count_d  = bits_acc;
                    state_d  = RX;
                end
            end
            RX: begin
                if (abort_i) begin
                    lfsr_clr = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE;
                end else if (valid_i) begin
                    lfsr_en  = 1'b1;
                    bits_acc = count_q + CW'(1);
                    count_d  = bits_acc;
                    if (!last_i && (bits_acc == CW'(MAX_FRAME_BITS))) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (abort_i) begin
                    lfsr_clr = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_end) begin
            count_d = '0;
            state_d = IDLE;
        end
    end

    // Once in DROP the LFSR is frozen, so the held register is the residue.
    always_comb begin
        len_err_d = (bits_acc < CW'(MIN_FRAME_BITS)) || (state_q == DROP);
        residue_d = (state_q == DROP) ? lfsr_q : lfsr_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q       <= 1'b0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            frame_bits_q <= '0;
            residue_q    <= '0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                crc_ok_q     <= (residue_d == '0) && !len_err_d;
                len_err_q    <= len_err_d;
                frame_bits_q <= bits_acc;
                residue_q    <= residue_d;
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign crc_ok_o     = crc_ok_q;
    assign len_err_o    = len_err_q;
    assign frame_bits_o = frame_bits_q;
    assign residue_o    = residue_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: a default-size instance and a
// MAX_FRAME_BITS=64 instance for the overflow case.
module tb_crc16_frame_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        da = 1'b0, va = 1'b0, la = 1'b0, aa = 1'b0;
    logic        busy_a, done_a, ok_a, lerr_a;
    logic [12:0] bits_a;
    logic [15:0] res_a;

    logic        db = 1'b0, vb = 1'b0, lb = 1'b0, ab = 1'b0;
    logic        busy_b, done_b, ok_b, lerr_b;
    logic [6:0]  bits_b;
    logic [15:0] res_b;

    crc16_frame_checker u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (da),
        .valid_i      (va),
        .last_i       (la),
        .abort_i      (aa),
        .busy_o       (busy_a),
        .done_o       (done_a),
        .crc_ok_o     (ok_a),
        .len_err_o    (lerr_a),
        .frame_bits_o (bits_a),
        .residue_o    (res_a)
    );

    crc16_frame_checker #(
        .MAX_FRAME_BITS (64)
    ) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (db),
        .valid_i      (vb),
        .last_i       (lb),
        .abort_i      (ab),
        .busy_o       (busy_b),
        .done_o       (done_b),
        .crc_ok_o     (ok_b),
        .len_err_o    (lerr_b),
        .frame_bits_o (bits_b),
        .residue_o    (res_b)
    );

    typedef struct {
        logic        ok;
        logic        lerr;
        int          bits;
        logic [15:0] res;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR written out bit by bit from the register equations.
    function automatic logic [15:0] model_step(input logic [15:0] r, input logic d);
        logic        f;
        logic [15:0] n;
        f       = d ^ r[15];
        n[0]    = f;
        n[1]    = r[0];
        n[2]    = r[1] ^ f;
        n[14:3] = r[13:2];
        n[15]   = r[14] ^ f;
        return n;
    endfunction

    task automatic drive_bit(input int sel, input logic d, input logic l);
        if (sel == 0) begin
            da = d; va = 1'b1; la = l;
        end else begin
            db = d; vb = 1'b1; lb = l;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        va = 1'b0; la = 1'b0; aa = 1'b0;
        vb = 1'b0; lb = 1'b0; ab = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [127:0] f, input int n, input int max_bits);
        exp_t        e;
        logic [15:0] r;
        int          cnt;
        r   = 16'h0000;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (cnt < max_bits) begin
                r = model_step(r, f[n-1-i]);
                cnt++;
            end
        end
        e.res  = r;
        e.bits = cnt;
        e.lerr = (n < 17) || (n > max_bits);
        e.ok   = (r == 16'h0000) && !e.lerr;
        if (sel == 0) q_a.push_back(e);
        else q_b.push_back(e);
        for (int i = 0; i < n; i++) drive_bit(sel, f[n-1-i], i == n - 1);
    endtask

    // Expected done pulse: one cycle after an accepted last bit.
    logic ed_a, ed_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ed_a <= 1'b0;
            ed_b <= 1'b0;
        end else begin
            ed_a <= va && la && !aa;
            ed_b <= vb && lb && !ab;
        end
    end

    exp_t ea;
    always @(negedge clk) begin
        if (!rst && (done_a || ed_a)) begin
            check("done_a", {31'b0, done_a}, {31'b0, ed_a});
            if (done_a) begin
                if (q_a.size() == 0) begin
                    check("sb_a_underflow", 32'(q_a.size()), 32'd1);
                end else begin
                    ea = q_a.pop_front();
                    check("a_crc_ok", {31'b0, ok_a}, {31'b0, ea.ok});
                    check("a_len_err", {31'b0, lerr_a}, {31'b0, ea.lerr});
                    check("a_frame_bits", {19'b0, bits_a}, ea.bits);
                    check("a_residue", {16'b0, res_a}, {16'b0, ea.res});
                end
            end
        end
    end

    exp_t eb;
    always @(negedge clk) begin
        if (!rst && (done_b || ed_b)) begin
            check("done_b", {31'b0, done_b}, {31'b0, ed_b});
            if (done_b) begin
                if (q_b.size() == 0) begin
                    check("sb_b_underflow", 32'(q_b.size()), 32'd1);
                end else begin
                    eb = q_b.pop_front();
                    check("b_crc_ok", {31'b0, ok_b}, {31'b0, eb.ok});
                    check("b_len_err", {31'b0, lerr_b}, {31'b0, eb.lerr});
                    check("b_frame_bits", {25'b0, bits_b}, eb.bits);
                    check("b_residue", {16'b0, res_b}, {16'b0, eb.res});
                end
            end
        end
    end

    logic [127:0] f1, f2, f2_bad, f4, f_zero;
    logic [71:0]  ascii;

    initial begin
        f1     = {104'b0, 8'h01, 16'h8005};
        ascii  = "123456789";
        f2     = {40'b0, ascii, 16'hFEE8};
        f2_bad = f2 ^ (128'b1 << (88 - 1 - 5));
        f4     = {58'b0, 64'hDEAD_BEEF_1234_5678, 6'b101101};
        f_zero = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        check("rst_ok", {31'b0, ok_a}, 32'd0);
        check("rst_bits", {19'b0, bits_a}, 32'd0);
        check("rst_res", {16'b0, res_a}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Test 1: 0x01 + CRC 0x8005
        send(0, f1, 24, 4096);
        idle(2);
        check("t1_res", {16'b0, res_a}, 32'h0000);
        check("t1_bits", {19'b0, bits_a}, 32'd24);
        check("t1_ok", {31'b0, ok_a}, 32'd1);

        // Test 2: check string, then single-bit error
        send(0, f2, 88, 4096);
        idle(2);
        check("t2_ok", {31'b0, ok_a}, 32'd1);
        send(0, f2_bad, 88, 4096);
        idle(2);
        check("t2_bad_ok", {31'b0, ok_a}, 32'd0);
        check("t2_bad_res_nz", {31'b0, res_a != 16'h0000}, 32'd1);

        // Test 3: too-short all-zero frame
        send(0, f_zero, 16, 4096);
        idle(2);
        check("t3_len_err", {31'b0, lerr_a}, 32'd1);
        check("t3_ok", {31'b0, ok_a}, 32'd0);

        // Test 4: overflow on the 64-bit instance
        send(1, f4, 70, 64);
        idle(2);
        check("t4_len_err", {31'b0, lerr_b}, 32'd1);
        check("t4_bits", {25'b0, bits_b}, 32'd64);
        check("t4_busy", {31'b0, busy_b}, 32'd0);

        // Test 5: abort after 10 bits, abort+valid drops the 11th bit
        for (int i = 0; i < 10; i++) drive_bit(0, i[0], 1'b0);
        check("t5_busy_mid", {31'b0, busy_a}, 32'd1);
        aa = 1'b1;
        drive_bit(0, 1'b1, 1'b1);
        aa = 1'b0;
        check("t5_busy_abort", {31'b0, busy_a}, 32'd0);
        idle(3);
        check("t5_held_len_err", {31'b0, lerr_a}, 32'd1);
        send(0, f1, 24, 4096);
        idle(2);
        check("t5_ok", {31'b0, ok_a}, 32'd1);

        // Test 6: back-to-back frames, then reset mid-frame
        send(0, f1, 24, 4096);
        send(0, f1, 24, 4096);
        for (int i = 0; i < 5; i++) drive_bit(0, 1'b1, 1'b0);
        check("t6_pre_ok", {31'b0, ok_a}, 32'd1);
        rst = 1'b1;
        va  = 1'b0;
        #1;
        check("t6_rst_busy", {31'b0, busy_a}, 32'd0);
        check("t6_rst_done", {31'b0, done_a}, 32'd0);
        check("t6_rst_ok", {31'b0, ok_a}, 32'd0);
        check("t6_rst_len_err", {31'b0, lerr_a}, 32'd0);
        check("t6_rst_bits", {19'b0, bits_a}, 32'd0);
        check("t6_rst_res", {16'b0, res_a}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(3);

        check("sb_a_drained", 32'(q_a.size()), 32'd0);
        check("sb_b_drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
